// File: rtl/coproc0_exc_seq_pkg.sv
// Shared constants for the CP0 exception sequencer.
//   - ExcCode values written to Cause.ExcCode
//   - exception vector address
//   - sequencer state encoding
//   - EPC restart-address helper
package coproc0_exc_seq_pkg;

  localparam logic [31:0] Vector = 32'h0000_0080;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcIbe  = 5'd6;
  localparam logic [4:0] ExcDbe  = 5'd7;
  localparam logic [4:0] ExcSys  = 5'd8;
  localparam logic [4:0] ExcBp   = 5'd9;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRedirect
  } seq_state_e;

  // A fault in a delay slot restarts at the branch, one word earlier (wraps at 0).
  function automatic logic [31:0] restart_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/coproc0_exc_prio.sv
// Combinational precise-exception priority select.
// Oldest instruction wins: mem > exu > ifu > interrupt.
// Inputs : per-stage request/code/pc/bd(/badva), interrupt lines and Status gating.
// Outputs: win_valid_o, win_code_o, win_pc_o, win_bd_o, win_badva_o, win_badva_vld_o.
module coproc0_exc_prio
  import coproc0_exc_seq_pkg::*;
(
  input  logic        ifu_exc_i,
  input  logic [4:0]  ifu_code_i,
  input  logic [31:0] ifu_pc_i,
  input  logic        ifu_bd_i,
  input  logic [31:0] ifu_badva_i,
  input  logic        exu_exc_i,
  input  logic [4:0]  exu_code_i,
  input  logic [31:0] exu_pc_i,
  input  logic        exu_bd_i,
  input  logic        mem_exc_i,
  input  logic [4:0]  mem_code_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_bd_i,
  input  logic [31:0] mem_badva_i,
  input  logic [31:0] int_pc_i,
  input  logic        int_bd_i,
  input  logic [5:0]  hw_int_i,
  input  logic        sr_ie_i,
  input  logic        sr_exl_i,
  input  logic [5:0]  sr_im_i,
  output logic        win_valid_o,
  output logic [4:0]  win_code_o,
  output logic [31:0] win_pc_o,
  output logic        win_bd_o,
  output logic [31:0] win_badva_o,
  output logic        win_badva_vld_o
);

  logic int_req;

  // EXL masks interrupts only; synchronous exceptions are always taken.
  assign int_req = sr_ie_i & ~sr_exl_i & (|(hw_int_i & sr_im_i));

  always_comb begin
    win_valid_o     = 1'b0;
    win_code_o      = ExcInt;
    win_pc_o        = 32'd0;
    win_bd_o        = 1'b0;
    win_badva_o     = 32'd0;
    win_badva_vld_o = 1'b0;
    if (mem_exc_i) begin
      win_valid_o     = 1'b1;
      win_code_o      = mem_code_i;
      win_pc_o        = mem_pc_i;
      win_bd_o        = mem_bd_i;
      win_badva_o     = mem_badva_i;
      win_badva_vld_o = 1'b1;
    end else if (exu_exc_i) begin
      win_valid_o = 1'b1;
      win_code_o  = exu_code_i;
      win_pc_o    = exu_pc_i;
      win_bd_o    = exu_bd_i;
    end else if (ifu_exc_i) begin
      win_valid_o     = 1'b1;
      win_code_o      = ifu_code_i;
      win_pc_o        = ifu_pc_i;
      win_bd_o        = ifu_bd_i;
      win_badva_o     = ifu_badva_i;
      win_badva_vld_o = 1'b1;
    end else if (int_req) begin
      win_valid_o = 1'b1;
      win_code_o  = ExcInt;
      win_pc_o    = int_pc_i;
      win_bd_o    = int_bd_i;
    end
  end

endmodule

// File: rtl/coproc0_exc_seq.sv
// CP0 exception entry sequencer.
// IDLE latches the highest-priority event, FLUSH (one cycle) kills the pipeline and
// strobes the EPC/Cause/BadVAddr/EXL writes, REDIRECT holds a PC redirect to the
// exception vector until fetch accepts it.
// Inputs : stage exception requests, interrupt lines, Status bits, redirect_ready_i.
// Outputs: flush_o, busy_o, CP0 write strobes/data, redirect_valid_o/redirect_pc_o.
// All outputs decode from the state register and latched event data.
module coproc0_exc_seq
  import coproc0_exc_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ifu_exc_i,
  input  logic [4:0]  ifu_code_i,
  input  logic [31:0] ifu_pc_i,
  input  logic        ifu_bd_i,
  input  logic [31:0] ifu_badva_i,
  input  logic        exu_exc_i,
  input  logic [4:0]  exu_code_i,
  input  logic [31:0] exu_pc_i,
  input  logic        exu_bd_i,
  input  logic        mem_exc_i,
  input  logic [4:0]  mem_code_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_bd_i,
  input  logic [31:0] mem_badva_i,
  input  logic [31:0] int_pc_i,
  input  logic        int_bd_i,
  input  logic [5:0]  hw_int_i,
  input  logic        sr_ie_i,
  input  logic        sr_exl_i,
  input  logic [5:0]  sr_im_i,
  input  logic        redirect_ready_i,
  output logic        flush_o,
  output logic        busy_o,
  output logic        epc_we_o,
  output logic [31:0] epc_o,
  output logic        cause_we_o,
  output logic [4:0]  cause_code_o,
  output logic        cause_bd_o,
  output logic        badva_we_o,
  output logic [31:0] badva_o,
  output logic        exl_set_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  seq_state_e  state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] badva_q, badva_d;
  logic        badva_vld_q, badva_vld_d;

  logic        win_valid;
  logic [4:0]  win_code;
  logic [31:0] win_pc;
  logic        win_bd;
  logic [31:0] win_badva;
  logic        win_badva_vld;

  coproc0_exc_prio u_prio (
    .ifu_exc_i       (ifu_exc_i),
    .ifu_code_i      (ifu_code_i),
    .ifu_pc_i        (ifu_pc_i),
    .ifu_bd_i        (ifu_bd_i),
    .ifu_badva_i     (ifu_badva_i),
    .exu_exc_i       (exu_exc_i),
    .exu_code_i      (exu_code_i),
    .exu_pc_i        (exu_pc_i),
    .exu_bd_i        (exu_bd_i),
    .mem_exc_i       (mem_exc_i),
    .mem_code_i      (mem_code_i),
    .mem_pc_i        (mem_pc_i),
    .mem_bd_i        (mem_bd_i),
    .mem_badva_i     (mem_badva_i),
    .int_pc_i        (int_pc_i),
    .int_bd_i        (int_bd_i),
    .hw_int_i        (hw_int_i),
    .sr_ie_i         (sr_ie_i),
    .sr_exl_i        (sr_exl_i),
    .sr_im_i         (sr_im_i),
    .win_valid_o     (win_valid),
    .win_code_o      (win_code),
    .win_pc_o        (win_pc),
    .win_bd_o        (win_bd),
    .win_badva_o     (win_badva),
    .win_badva_vld_o (win_badva_vld)
  );

  // Next-state: requests are only looked at in IDLE; anything arriving later is
  // dropped by the stages on flush.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    pc_d        = pc_q;
    bd_d        = bd_q;
    badva_d     = badva_q;
    badva_vld_d = badva_vld_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d     = StFlush;
          code_d      = win_code;
          pc_d        = win_pc;
          bd_d        = win_bd;
          badva_d     = win_badva;
          badva_vld_d = win_badva_vld;
        end
      end
      StFlush: state_d = StRedirect;
      StRedirect: begin
        if (redirect_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      code_q      <= 5'd0;
      pc_q        <= 32'd0;
      bd_q        <= 1'b0;
      badva_q     <= 32'd0;
      badva_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      pc_q        <= pc_d;
      bd_q        <= bd_d;
      badva_q     <= badva_d;
      badva_vld_q <= badva_vld_d;
    end
  end

  // Data outputs are zeroed outside their strobe window so a reset mid-sequence
  // leaves every output at 0 immediately.
  always_comb begin
    flush_o          = 1'b0;
    busy_o           = 1'b0;
    epc_we_o         = 1'b0;
    epc_o            = 32'd0;
    cause_we_o       = 1'b0;
    cause_code_o     = 5'd0;
    cause_bd_o       = 1'b0;
    badva_we_o       = 1'b0;
    badva_o          = 32'd0;
    exl_set_o        = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    unique case (state_q)
      StIdle: ;
      StFlush: begin
        busy_o       = 1'b1;
        flush_o      = 1'b1;
        epc_we_o     = 1'b1;
        epc_o        = restart_epc(pc_q, bd_q);
        cause_we_o   = 1'b1;
        cause_code_o = code_q;
        cause_bd_o   = bd_q;
        badva_we_o   = badva_vld_q;
        badva_o      = badva_vld_q ? badva_q : 32'd0;
        exl_set_o    = 1'b1;
      end
      StRedirect: begin
        busy_o           = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = Vector;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coproc0_exc_seq.sv
module tb_coproc0_exc_seq;

  logic        clk, rst;
  logic        ifu_exc, exu_exc, mem_exc;
  logic [4:0]  ifu_code, exu_code, mem_code;
  logic [31:0] ifu_pc, exu_pc, mem_pc, ifu_badva, mem_badva, int_pc;
  logic        ifu_bd, exu_bd, mem_bd, int_bd;
  logic [5:0]  hw_int, sr_im;
  logic        sr_ie, sr_exl, redirect_ready;
  logic        flush, busy, epc_we, cause_we, cause_bd, badva_we, exl_set, redirect_valid;
  logic [31:0] epc, badva, redirect_pc;
  logic [4:0]  cause_code;

  coproc0_exc_seq dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifu_exc_i        (ifu_exc),
    .ifu_code_i       (ifu_code),
    .ifu_pc_i         (ifu_pc),
    .ifu_bd_i         (ifu_bd),
    .ifu_badva_i      (ifu_badva),
    .exu_exc_i        (exu_exc),
    .exu_code_i       (exu_code),
    .exu_pc_i         (exu_pc),
    .exu_bd_i         (exu_bd),
    .mem_exc_i        (mem_exc),
    .mem_code_i       (mem_code),
    .mem_pc_i         (mem_pc),
    .mem_bd_i         (mem_bd),
    .mem_badva_i      (mem_badva),
    .int_pc_i         (int_pc),
    .int_bd_i         (int_bd),
    .hw_int_i         (hw_int),
    .sr_ie_i          (sr_ie),
    .sr_exl_i         (sr_exl),
    .sr_im_i          (sr_im),
    .redirect_ready_i (redirect_ready),
    .flush_o          (flush),
    .busy_o           (busy),
    .epc_we_o         (epc_we),
    .epc_o            (epc),
    .cause_we_o       (cause_we),
    .cause_code_o     (cause_code),
    .cause_bd_o       (cause_bd),
    .badva_we_o       (badva_we),
    .badva_o          (badva),
    .exl_set_o        (exl_set),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc)
  );

  typedef struct packed {
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic        bwe;
    logic [31:0] badva;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: oldest stage wins; interrupts only when enabled, unmasked and EXL clear.
  task automatic predict(output bit take, output exp_t e);
    logic [31:0] pc;
    bit irq;
    irq  = sr_ie && !sr_exl && ((hw_int & sr_im) != 6'd0);
    take = 1'b1;
    e    = '0;
    if (mem_exc) begin
      e.code = mem_code; pc = mem_pc; e.bd = mem_bd; e.bwe = 1'b1; e.badva = mem_badva;
    end else if (exu_exc) begin
      e.code = exu_code; pc = exu_pc; e.bd = exu_bd;
    end else if (ifu_exc) begin
      e.code = ifu_code; pc = ifu_pc; e.bd = ifu_bd; e.bwe = 1'b1; e.badva = ifu_badva;
    end else if (irq) begin
      e.code = 5'd0; pc = int_pc; e.bd = int_bd;
    end else begin
      take = 1'b0; pc = 32'd0;
    end
    e.epc = e.bd ? pc - 32'd4 : pc;
  endtask

  task automatic clear_reqs();
    ifu_exc = 1'b0; exu_exc = 1'b0; mem_exc = 1'b0; hw_int = 6'd0;
  endtask

  // Called at a negedge with the DUT idle and requests already driven.
  task automatic run_txn(input int stall, input bit inject);
    bit   take;
    exp_t e;
    predict(take, e);
    if (take) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);          // FLUSH cycle, scoreboard checks the strobes
    clear_reqs();
    if (!take) begin
      check("no_entry_busy", {31'd0, busy}, 32'd0);
      return;
    end
    @(negedge clk);          // first REDIRECT cycle
    check("redir_valid", {31'd0, redirect_valid}, 32'd1);
    check("redir_pc", redirect_pc, 32'h80);
    check("redir_busy", {31'd0, busy}, 32'd1);
    if (inject) begin
      exu_exc = 1'b1; exu_code = 5'd12; exu_pc = $urandom; exu_bd = 1'b0;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, redirect_valid}, 32'd1);
      check("hold_pc", redirect_pc, 32'h80);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    exu_exc = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, redirect_valid}, 32'd0);
  endtask

  // Scoreboard monitor: every strobe cycle must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (flush) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_flush: got flush=1 expected no entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("epc_we", {31'd0, epc_we}, 32'd1);
            check("cause_we", {31'd0, cause_we}, 32'd1);
            check("exl_set", {31'd0, exl_set}, 32'd1);
            check("epc", epc, e.epc);
            check("cause_code", {27'd0, cause_code}, {27'd0, e.code});
            check("cause_bd", {31'd0, cause_bd}, {31'd0, e.bd});
            check("badva_we", {31'd0, badva_we}, {31'd0, e.bwe});
            if (e.bwe) check("badva", badva, e.badva);
          end
        end else begin
          check("quiet_strobes", {28'd0, epc_we, cause_we, exl_set, badva_we}, 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_ready = 1'b0;
    clear_reqs();
    ifu_code = '0; exu_code = '0; mem_code = '0;
    ifu_pc = '0; exu_pc = '0; mem_pc = '0; ifu_badva = '0; mem_badva = '0; int_pc = '0;
    ifu_bd = 1'b0; exu_bd = 1'b0; mem_bd = 1'b0; int_bd = 1'b0;
    sr_im = '0; sr_ie = 1'b0; sr_exl = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {23'd0, flush, busy, epc_we, cause_we, cause_bd, badva_we, exl_set,
                       redirect_valid, 1'b0}, 32'd0);
    check("rst_data", epc | badva | redirect_pc | {27'd0, cause_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // exu overflow alone, redirect held 5 cycles with an ignored new request
    exu_exc = 1'b1; exu_code = 5'd12; exu_pc = 32'h100; exu_bd = 1'b0;
    run_txn(5, 1'b1);

    // mem ADEL beats ifu IBE
    mem_exc = 1'b1; mem_code = 5'd4; mem_pc = 32'h200; mem_bd = 1'b0; mem_badva = 32'h1003;
    ifu_exc = 1'b1; ifu_code = 5'd6; ifu_pc = 32'h300; ifu_badva = 32'h300;
    run_txn(0, 1'b0);

    // delay-slot fault at PC 0 wraps
    mem_exc = 1'b1; mem_code = 5'd7; mem_pc = 32'h0; mem_bd = 1'b1; mem_badva = 32'h44;
    run_txn(1, 1'b0);

    // interrupt blocked by EXL, then taken
    hw_int = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1; sr_exl = 1'b1;
    int_pc = 32'h1234; int_bd = 1'b0;
    run_txn(0, 1'b0);
    hw_int = 6'b000100; sr_exl = 1'b0;
    run_txn(2, 1'b0);

    // EXL does not block a synchronous exception
    sr_exl = 1'b1; ifu_exc = 1'b1; ifu_code = 5'd6; ifu_pc = 32'h400; ifu_bd = 1'b1;
    ifu_badva = 32'h400;
    run_txn(0, 1'b0);
    sr_exl = 1'b0;

    // reset while in REDIRECT
    exu_exc = 1'b1; exu_code = 5'd8; exu_pc = 32'h500; exu_bd = 1'b0;
    exp_q.push_back('{epc: 32'h500, code: 5'd8, bd: 1'b0, bwe: 1'b0, badva: 32'd0});
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, redirect_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      mem_exc = ($urandom_range(3) == 0);
      exu_exc = ($urandom_range(3) == 0);
      ifu_exc = ($urandom_range(3) == 0);
      mem_code = 5'($urandom_range(4, 7)); exu_code = 5'($urandom_range(8, 12));
      ifu_code = 5'($urandom_range(4, 6));
      mem_pc = ($urandom_range(3) == 0) ? 32'd0 : {$urandom} & 32'hFFFF_FFFC;
      exu_pc = {$urandom} & 32'hFFFF_FFFC; ifu_pc = {$urandom} & 32'hFFFF_FFFC;
      int_pc = {$urandom} & 32'hFFFF_FFFC;
      mem_bd = 1'($urandom); exu_bd = 1'($urandom); ifu_bd = 1'($urandom);
      int_bd = 1'($urandom);
      mem_badva = $urandom; ifu_badva = $urandom;
      hw_int = 6'($urandom); sr_im = 6'($urandom);
      sr_ie = 1'($urandom); sr_exl = 1'($urandom);
      run_txn($urandom_range(0, 3), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coproc0_exc_seq.md
# coproc0_exc_seq

Exception sequencer for the Coprocessor 0 Exceptions and Interrupts Unit.
- Collects synchronous exception requests from the fetch, execute and memory stages, plus level-sensitive hardware interrupts.
- Selects one event by precise-exception priority.
- Sequences entry: pipeline flush, CP0 register updates (EPC/Cause/BadVAddr/EXL), then a handshaked PC redirect to the exception vector.
- Sits between the pipeline stages and the CP0 register file; it owns no architectural registers itself.

## Interface
- `VECTOR`, 32'h0000_0080: exception handler address driven on redirect.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ifu_exc` / `exu_exc` / `mem_exc`  in  1 each  exception request from fetch / execute / memory stage; level, held until flush.
- `ifu_code` / `exu_code` / `mem_code`  in  5 each  ExcCode of the request.
- `ifu_pc` / `exu_pc` / `mem_pc`  in  32 each  PC of the faulting instruction.
- `ifu_bd` / `exu_bd` / `mem_bd`  in  1 each  faulting instruction is in a delay slot.
- `ifu_badva` / `mem_badva`  in  32 each  faulting address (address/bus errors).
- `int_pc`  in  32  restart PC for an interrupt (oldest uncommitted instruction).
- `int_bd`  in  1  restart instruction is in a delay slot.
- `hw_int`  in  6  hardware interrupt lines; already synchronous to `clk`.
- `sr_ie`, `sr_exl`  in  1 each  Status.IE and Status.EXL.
- `sr_im`  in  6  Status.IM[7:2].
- `redirect_ready`  in  1  fetch accepts redirect.
- `flush`  out  1  kill all in-flight instructions; 1-cycle pulse.
- `busy`  out  1  sequencer not IDLE; pipeline must stall issue.
- `epc_we` + `epc`  out  1 + 32  EPC write.
- `cause_we` + `cause_code` + `cause_bd`  out  1 + 5 + 1  Cause write.
- `badva_we` + `badva`  out  1 + 32  BadVAddr write.
- `exl_set`  out  1  set Status.EXL.
- `redirect_valid` + `redirect_pc`  out  1 + 32  PC redirect.

## Operation
- Priority, oldest first: `mem_exc` > `exu_exc` > `ifu_exc` > interrupt.
- `int_req = sr_ie & ~sr_exl & |(hw_int & sr_im)`.
- Interrupt ExcCode = 5'd0.
- States: IDLE, FLUSH, REDIRECT.
- **IDLE**: if any request, or `int_req`, latch the winner's code, PC, BD and badva (badva only for mem/ifu winners; `badva_we` = 0 for exu/interrupt), then go to FLUSH. Otherwise stay.
- **FLUSH** (exactly 1 cycle):
  - assert `flush`, `epc_we`, `cause_we`, `exl_set`, and `badva_we` if applicable;
  - `epc` = latched PC − 4 when BD = 1, else latched PC (32-bit wrap, no carry out);
  - `cause_bd` = latched BD;
  - go to REDIRECT.
- **REDIRECT**: `redirect_valid` = 1, `redirect_pc` = `VECTOR`. On `redirect_valid & redirect_ready`, go to IDLE.
- Requests arriving while not IDLE are ignored; stages drop them on `flush`.
- A request still high in the IDLE cycle after REDIRECT is treated as new.
- Simultaneous mem + exu + int: mem wins; the others are discarded by the flush.
- `sr_exl` = 1 does not block synchronous exceptions; it blocks interrupts only.
- Reset mid-sequence: return to IDLE immediately; no partial register writes complete.

## Timing
- Reset values: all outputs 0, `redirect_pc` 0, state IDLE.
- Request sampled at edge N (IDLE) → FLUSH and write strobes high during cycle N+1 → `redirect_valid` from cycle N+2.
- Minimum entry latency is 3 cycles from request to the redirect-accept edge.
- `busy` is high in FLUSH and REDIRECT; it is registered (not combinational from requests).
- `redirect_valid` and `redirect_pc` stay stable until accepted.
- All outputs are registered or decoded from state/latched data only.

## Structure
- Shared package `cpu_const`: ExcCode constants (INT=0, ADEL=4, ADES=5, IBE=6, DBE=7, SYS=8, BP=9, RI=10, OV=12) and state encoding.
- Optional sub-module `coproc0_exc_prio`: combinational priority select producing winner valid, code, PC, BD, badva and badva-valid.
- `coproc0_eiu` instantiates this block.

## Test plan
- **exu overflow alone**: `exu_exc`=1, `exu_code`=12, `exu_pc`=0x100, `exu_bd`=0 → next cycle `flush`, `epc`=0x100, `cause_code`=12, no `badva_we`. Then `redirect_pc`=0x80 held until `redirect_ready`.
- **Simultaneous mem ADEL + ifu IBE**: `mem_pc`=0x200, `mem_badva`=0x1003 → `cause_code`=4, `epc`=0x200, `badva`=0x1003; ifu request discarded.
- **Delay-slot fault**: `mem_bd`=1, `mem_pc`=0x0 → `epc`=0xFFFF_FFFC (wrap), `cause_bd`=1.
- **Interrupt gating**: `hw_int`=6'b000100, `sr_im`=6'b000100, `sr_ie`=1 with `sr_exl` toggled 1 → no entry; with `sr_exl`=0 → `cause_code`=0, `epc`=`int_pc`.
- **Redirect backpressure**: `redirect_ready` held low 5 cycles → `redirect_valid` stays high, `busy` stays high, a new `exu_exc` is ignored; accept → IDLE, then new request taken.
- **Reset mid-sequence**: assert `rst` in REDIRECT → all outputs 0 asynchronously; after release, IDLE with no spurious strobes.
